store_lane_unit: RTL and testbench

Parametrised store path between the execute stage and the data memory port: takes a store request (address, funct3, register data), derives per-byte write enables and lane-aligned write data for any data width, and issues one or two memory beats over a valid/ready handshake. Stores crossing a word boundary are split into two beats when enabled. Illegal stores raise a one-cycle error pulse instead. Generalises the fixed 4-lane sb/sh/sw enable decode to 32/64-bit datapaths, sub-word address offsets and misaligned accesses.

---
 rtl/store_lane_unit.sv | 180 ++++++++++++++++++
 tb/tb_store_lane_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/store_lane_unit.sv
// Store path from execute to the data memory port: byte-enable/lane-alignment decode,
// optional two-beat split for word-crossing stores, and a one-cycle error pulse for illegal stores.

module store_lane_byte #(
  parameter int NB    = 4,
  parameter int OFS_W = 2,
  parameter int LANE  = 0
) (
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [3:0]        size_i,
  input  logic [NB*8-1:0]   wdata_i,
  output logic              we_o,
  output logic [7:0]        byte_o
);
  localparam int KW = OFS_W + 2;

  logic [KW-1:0]      lane_c;
  logic [KW-1:0]      k;
  logic [NB-1:0][7:0] src;
  logic               hit;

  // Lane j of the double-width window carries store byte (j - ofs) when it falls inside the access.
  assign lane_c = KW'(LANE);
  assign k      = lane_c - KW'(ofs_i);
  assign src    = wdata_i;
  assign hit    = (lane_c >= KW'(ofs_i)) && (8'(k) < 8'(size_i));
  assign we_o   = hit;
  assign byte_o = hit ? src[k[OFS_W-1:0]] : 8'h00;
endmodule

module store_lane_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              store_err,
  output logic              busy
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     we_q, we_d, hi_we_q, hi_we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, hi_wdata_q, hi_wdata_d;
  logic              valid_q, valid_d, err_q, err_d, busy_q, busy_d;

  logic                 accept;
  logic [3:0]           size_c;
  logic [OFS_W-1:0]     ofs_c;
  logic                 illegal;
  logic [2*NB-1:0]      wide_we;
  logic [2*NB-1:0][7:0] wide_b;
  logic [XLEN-1:0]      lo_data, hi_data;
  logic [ADDR_W-1:0]    base_addr;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign size_c    = 4'd1 << req_funct3[1:0];
  assign ofs_c     = req_addr[OFS_W-1:0];
  assign base_addr = req_addr & ~ADDR_W'(NB - 1);

  assign illegal = req_funct3[2]
                || ((XLEN == 32) && (req_funct3[1:0] == 2'b11))
                || (!ALLOW_MISALIGNED && ((4'(ofs_c) & (size_c - 4'd1)) != 4'd0));

  for (genvar j = 0; j < 2*NB; j++) begin : g_lane
    store_lane_byte #(.NB(NB), .OFS_W(OFS_W), .LANE(j)) u_lane (
      .ofs_i   (ofs_c),
      .size_i  (size_c),
      .wdata_i (req_wdata),
      .we_o    (wide_we[j]),
      .byte_o  (wide_b[j])
    );
  end

  assign lo_data = wide_b[NB-1:0];
  assign hi_data = wide_b[2*NB-1:NB];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    hi_we_d    = hi_we_q;
    hi_wdata_d = hi_wdata_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        busy_d = 1'b1;
        if (illegal) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d    = BEAT0;
          valid_d    = 1'b1;
          addr_d     = base_addr;
          we_d       = wide_we[NB-1:0];
          wdata_d    = lo_data;
          hi_we_d    = wide_we[2*NB-1:NB];
          hi_wdata_d = hi_data;
        end
      end
      BEAT0: if (mem_ready) begin
        if (|hi_we_q) begin
          // Second beat goes to the next word; wraps at the top of the address space.
          state_d = BEAT1;
          addr_d  = addr_q + ADDR_W'(NB);
          we_d    = hi_we_q;
          wdata_d = hi_wdata_q;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          we_d    = '0;
          wdata_d = '0;
        end
      end
      BEAT1: if (mem_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        we_d    = '0;
        wdata_d = '0;
      end
      ERR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      hi_we_q    <= '0;
      hi_wdata_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      hi_we_q    <= hi_we_d;
      hi_wdata_q <= hi_wdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_valid = valid_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign store_err = err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_store_lane_unit.sv
// Directed bench: three instances (32-bit misaligned-split, 32-bit strict, 64-bit) driven one at a time.

module tb_store_lane_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_wdata;
  logic [2:0]  rv;
  int          total = 0;
  int          bad   = 0;

  logic [2:0]  rdy, mv, err, bsy;
  logic [31:0] ma [3];
  logic [3:0]  we32a, we32b;
  logic [7:0]  we64;
  logic [31:0] wd32a, wd32b;
  logic [63:0] wd64;

  always #5 clk = ~clk;

  store_lane_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata[31:0]),
    .mem_valid(mv[0]), .mem_ready(mem_ready), .mem_addr(ma[0]), .mem_we(we32a),
    .mem_wdata(wd32a), .store_err(err[0]), .busy(bsy[0]));

  store_lane_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_s (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata[31:0]),
    .mem_valid(mv[1]), .mem_ready(mem_ready), .mem_addr(ma[1]), .mem_we(we32b),
    .mem_wdata(wd32b), .store_err(err[1]), .busy(bsy[1]));

  store_lane_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .mem_valid(mv[2]), .mem_ready(mem_ready), .mem_addr(ma[2]), .mem_we(we64),
    .mem_wdata(wd64), .store_err(err[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] we_of(input int s);
    case (s)
      0:       return 64'(we32a);
      1:       return 64'(we32b);
      default: return 64'(we64);
    endcase
  endfunction

  function automatic logic [63:0] wd_of(input int s);
    case (s)
      0:       return 64'(wd32a);
      1:       return 64'(wd32b);
      default: return wd64;
    endcase
  endfunction

  task automatic beat(input int s, input string tag, input logic [31:0] a,
                      input logic [63:0] we, input logic [63:0] d);
    chk({tag, ".valid"}, 64'(mv[s]), 64'd1);
    chk({tag, ".addr"},  64'(ma[s]), 64'(a));
    chk({tag, ".we"},    we_of(s),   we);
    chk({tag, ".wdata"}, wd_of(s),   d);
    chk({tag, ".rdy"},   64'(rdy[s]), 64'd0);
  endtask

  task automatic idle(input int s, input string tag);
    chk({tag, ".valid"}, 64'(mv[s]),  64'd0);
    chk({tag, ".rdy"},   64'(rdy[s]), 64'd1);
    chk({tag, ".busy"},  64'(bsy[s]), 64'd0);
  endtask

  task automatic issue(input int s, input logic [31:0] a, input logic [2:0] f3, input logic [63:0] d);
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = d;
    rv[s]      = 1'b1;
    step();
    rv         = '0;
    req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  initial begin
    rst_n = 1'b0; rv = '0; mem_ready = 1'b1;
    req_addr = '0; req_funct3 = '0; req_wdata = '0;
    step(); step();
    for (int s = 0; s < 3; s++) begin
      idle(s, "rst");
      chk("rst.err",   64'(err[s]), 64'd0);
      chk("rst.addr",  64'(ma[s]),  64'd0);
      chk("rst.we",    we_of(s),    64'd0);
      chk("rst.wdata", wd_of(s),    64'd0);
    end
    rst_n = 1'b1;
    step();

    // sb inside one word
    issue(0, 32'h1003, 3'b000, 64'hAABBCCDD);
    beat(0, "sb", 32'h1000, 64'h8, 64'hDD000000);
    step();
    idle(0, "sb.done");

    // sh crossing the word boundary -> two consecutive beats
    issue(0, 32'h1003, 3'b001, 64'h0000CCDD);
    beat(0, "sh.b0", 32'h1000, 64'h8, 64'hDD000000);
    step();
    beat(0, "sh.b1", 32'h1004, 64'h1, 64'h000000CC);
    step();
    idle(0, "sh.done");

    // sw held by backpressure for three cycles
    mem_ready = 1'b0;
    issue(0, 32'h2000, 3'b010, 64'h12345678);
    for (int i = 0; i < 4; i++) begin
      beat(0, "sw.stall", 32'h2000, 64'hF, 64'h12345678);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    idle(0, "sw.done");

    // split store at the top word wraps beat1 to address 0
    issue(0, 32'hFFFF_FFFF, 3'b001, 64'hBEEF);
    beat(0, "wrap.b0", 32'hFFFF_FFFC, 64'h8, 64'hEF000000);
    step();
    beat(0, "wrap.b1", 32'h0, 64'h1, 64'h000000BE);
    step();
    idle(0, "wrap.done");

    // sd is illegal on a 32-bit datapath
    issue(0, 32'h1000, 3'b011, 64'h1);
    chk("sd32.err",   64'(err[0]), 64'd1);
    chk("sd32.valid", 64'(mv[0]),  64'd0);
    chk("sd32.rdy",   64'(rdy[0]), 64'd0);
    step();
    chk("sd32.pulse", 64'(err[0]), 64'd0);
    idle(0, "sd32.done");

    // strict instance: misaligned sh errors, aligned sh is one beat
    issue(1, 32'h1001, 3'b001, 64'hCCDD);
    chk("mis.err",   64'(err[1]), 64'd1);
    chk("mis.valid", 64'(mv[1]),  64'd0);
    chk("mis.busy",  64'(bsy[1]), 64'd1);
    step();
    chk("mis.pulse", 64'(err[1]), 64'd0);
    idle(1, "mis.done");
    issue(1, 32'h1002, 3'b001, 64'hCCDD);
    chk("al.err", 64'(err[1]), 64'd0);
    beat(1, "al", 32'h1000, 64'hC, 64'hCCDD0000);
    step();
    idle(1, "al.done");

    // 64-bit datapath
    issue(2, 32'h8, 3'b011, 64'h0123456789ABCDEF);
    beat(2, "sd64", 32'h8, 64'hFF, 64'h0123456789ABCDEF);
    step();
    idle(2, "sd64.done");
    issue(2, 32'hC, 3'b010, 64'hFFFFFFFF12345678);
    beat(2, "sw64", 32'h8, 64'hF0, 64'h12345678_00000000);
    step();
    idle(2, "sw64.done");
    issue(2, 32'h6, 3'b010, 64'h12345678);
    beat(2, "sw64x.b0", 32'h0, 64'hC0, 64'h5678_0000_0000_0000);
    step();
    beat(2, "sw64x.b1", 32'h8, 64'h03, 64'h1234);
    step();
    idle(2, "sw64x.done");

    // reset while beat1 is stalled drops the store
    issue(0, 32'h1003, 3'b001, 64'hCCDD);
    step();
    mem_ready = 1'b0;
    beat(0, "rstmid.b1", 32'h1004, 64'h1, 64'h000000CC);
    rst_n = 1'b0;
    step();
    idle(0, "rstmid");
    chk("rstmid.we", we_of(0), 64'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    idle(0, "rstmid.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
